// File: rtl/bch_data_correct.sv
// Correction buffer: holds received data beats until the Chien search delivers matching error beats, then emits data ^ err.
// Optional macro BCH_CORRECT_COUNT_EN adds a per-word flipped-bit counter on out_flips.
module bch_data_correct #(
  parameter int DATA_BITS = 16,
  parameter int BITS      = 1,
  parameter int DEPTH     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic [BITS-1:0]                in_data,
  output logic                           in_ready,
  input  logic                           err_valid,
  input  logic                           err_first,
  input  logic [BITS-1:0]                err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BITS-1:0]                out_data,
  output logic                           out_first,
  output logic                           out_last,
  output logic [$clog2(DATA_BITS+1)-1:0] out_flips,
  output logic                           proto_err
);
  localparam int BEATS = DATA_BITS / BITS;
  localparam int CAP   = DEPTH * BEATS;
  localparam int PW    = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int CW    = $clog2(CAP + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW    = $clog2(DATA_BITS + 1);

  logic [BITS-1:0] d_mem_q [CAP];
  logic [BITS-1:0] e_mem_q [CAP];
  logic [PW-1:0]   d_wp_q, d_rp_q, e_wp_q, e_rp_q;
  logic [CW-1:0]   d_cnt_q, d_cnt_d, e_cnt_q, e_cnt_d;
  logic [BW-1:0]   ic_q, ec_q, oc_q;
  logic            proto_q, proto_d;
  logic            d_push, e_ok, e_push, pop;
  logic [BITS-1:0] d_head, e_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [BW-1:0] beat_inc(input logic [BW-1:0] c);
    return (c == BW'(BEATS - 1)) ? '0 : c + 1'b1;
  endfunction

  assign d_head    = d_mem_q[d_rp_q];
  assign e_head    = e_mem_q[e_rp_q];
  assign in_ready  = (d_cnt_q < CW'(CAP));
  assign out_valid = (d_cnt_q != '0) && (e_cnt_q != '0);
  assign out_data  = out_valid ? (d_head ^ e_head) : '0;
  assign out_first = out_valid && (oc_q == '0);
  assign out_last  = out_valid && (oc_q == BW'(BEATS - 1));
  assign proto_err = proto_q;

  // An error beat is only accepted when a data beat is already waiting for it.
  assign d_push = in_valid && in_ready;
  assign e_ok   = (e_cnt_q < CW'(CAP)) && (e_cnt_q < d_cnt_q);
  assign e_push = err_valid && e_ok;
  assign pop    = out_valid && out_ready;

  always_comb begin
    d_cnt_d = d_cnt_q;
    e_cnt_d = e_cnt_q;
    proto_d = proto_q;
    case ({d_push, pop})
      2'b10:   d_cnt_d = d_cnt_q + 1'b1;
      2'b01:   d_cnt_d = d_cnt_q - 1'b1;
      default: d_cnt_d = d_cnt_q;
    endcase
    case ({e_push, pop})
      2'b10:   e_cnt_d = e_cnt_q + 1'b1;
      2'b01:   e_cnt_d = e_cnt_q - 1'b1;
      default: e_cnt_d = e_cnt_q;
    endcase
    if (d_push && (in_first != (ic_q == '0)))
      proto_d = 1'b1;
    if (err_valid && ((err_first != (ec_q == '0)) || !e_ok))
      proto_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_wp_q  <= '0;
      d_rp_q  <= '0;
      e_wp_q  <= '0;
      e_rp_q  <= '0;
      d_cnt_q <= '0;
      e_cnt_q <= '0;
      ic_q    <= '0;
      ec_q    <= '0;
      oc_q    <= '0;
      proto_q <= 1'b0;
    end else begin
      d_cnt_q <= d_cnt_d;
      e_cnt_q <= e_cnt_d;
      proto_q <= proto_d;
      if (d_push) begin
        d_wp_q <= ptr_inc(d_wp_q);
        ic_q   <= beat_inc(ic_q);
      end
      if (e_push)
        e_wp_q <= ptr_inc(e_wp_q);
      if (err_valid)
        ec_q <= beat_inc(ec_q);
      if (pop) begin
        d_rp_q <= ptr_inc(d_rp_q);
        e_rp_q <= ptr_inc(e_rp_q);
        oc_q   <= beat_inc(oc_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (d_push)
      d_mem_q[d_wp_q] <= in_data;
    if (e_push)
      e_mem_q[e_wp_q] <= err;
  end

`ifdef BCH_CORRECT_COUNT_EN
  logic [FW-1:0] acc_q, acc_d, flips_now;

  function automatic logic [FW-1:0] popcnt(input logic [BITS-1:0] v);
    logic [FW-1:0] s;
    s = '0;
    for (int i = 0; i < BITS; i++)
      s = s + FW'(v[i]);
    return s;
  endfunction

  assign flips_now = acc_q + popcnt(e_head);
  assign out_flips = out_last ? flips_now : '0;

  always_comb begin
    acc_d = acc_q;
    if (pop)
      acc_d = out_last ? '0 : flips_now;
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end
`else
  assign out_flips = '0;
`endif

endmodule

// File: tb/tb_bch_data_correct.sv
// Randomized bench for bch_data_correct (DATA_BITS=16, BITS=4, DEPTH=2) against a queue-level reference model.
module tb_bch_data_correct;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_first, in_ready;
  logic [3:0] in_data;
  logic       err_valid, err_first;
  logic [3:0] err;
  logic       out_valid, out_ready, out_first, out_last, proto_err;
  logic [3:0] out_data;
  logic [4:0] out_flips;

  bch_data_correct #(.DATA_BITS(16), .BITS(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_first(in_first), .in_data(in_data), .in_ready(in_ready),
    .err_valid(err_valid), .err_first(err_first), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .out_flips(out_flips),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] v; logic f; } beat_t;
  beat_t      din_q[$], ein_q[$];
  logic [3:0] dq[$], eq[$];
  int         icnt, ecnt, ocnt, acc;
  bit         m_proto;
  int         n_vec = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_err(input logic [15:0] e);
    for (int k = 0; k < 4; k++) ein_q.push_back('{e[4*k +: 4], k == 0});
  endtask

  task automatic add_word(input logic [15:0] d, input logic [15:0] e, input bit with_err);
    for (int k = 0; k < 4; k++) din_q.push_back('{d[4*k +: 4], k == 0});
    if (with_err) add_err(e);
  endtask

  task automatic model_clear();
    din_q.delete(); ein_q.delete(); dq.delete(); eq.delete();
    icnt = 0; ecnt = 0; ocnt = 0; acc = 0; m_proto = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 0; in_first = 0; in_data = 0;
    err_valid = 0; err_first = 0; err = 0; out_ready = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_first", out_first, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_flips", out_flips, 0);
    check_eq("rst_proto_err", proto_err, 0);
  endtask

  // ordy_mode: 0 = hold off, 1 = always ready, 2 = random; gaps randomizes valids; orphan forces an err beat.
  task automatic step(input int ordy_mode, input bit gaps, input bit orphan);
    bit exp_ready, exp_valid, pop, dpush, epush;
    int flips;
    in_valid = 0; in_first = 0; in_data = 0;
    err_valid = 0; err_first = 0; err = 0;
    if (din_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      in_valid = 1; in_data = din_q[0].v; in_first = din_q[0].f;
    end
    if (orphan) begin
      err_valid = 1; err_first = 1; err = 4'hF;
    end else if (ein_q.size() > 0 && eq.size() < dq.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
      err_valid = 1; err = ein_q[0].v; err_first = ein_q[0].f;
    end
    out_ready = (ordy_mode == 0) ? 1'b0 : (ordy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    exp_ready = dq.size() < 8;
    exp_valid = dq.size() > 0 && eq.size() > 0;
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, exp_valid);
    check_eq("proto_err", proto_err, m_proto);
    if (exp_valid) begin
      flips = 0;
`ifdef BCH_CORRECT_COUNT_EN
      if (ocnt == 3) flips = acc + $countones(eq[0]);
`endif
      check_eq("out_data", out_data, dq[0] ^ eq[0]);
      check_eq("out_first", out_first, ocnt == 0);
      check_eq("out_last", out_last, ocnt == 3);
      if (ocnt == 3) check_eq("out_flips", out_flips, flips);
    end
    pop   = exp_valid && out_ready;
    dpush = in_valid && exp_ready;
    epush = err_valid && eq.size() < 8 && eq.size() < dq.size();
    if (dpush) begin
      if (in_first != (icnt == 0)) m_proto = 1;
      icnt = (icnt + 1) % 4;
      void'(din_q.pop_front());
    end
    if (err_valid) begin
      if (err_first != (ecnt == 0) || !epush) m_proto = 1;
      ecnt = (ecnt + 1) % 4;
      if (!orphan) void'(ein_q.pop_front());
    end
    if (pop) begin
      acc = (ocnt == 3) ? 0 : acc + $countones(eq[0]);
      ocnt = (ocnt + 1) % 4;
      void'(dq.pop_front());
      void'(eq.pop_front());
    end
    if (dpush) dq.push_back(in_data);
    if (epush) eq.push_back(err);
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t b;
    logic [3:0] held;
    do_reset();

    // clean word, then the correction example
    add_word(16'h4321, 16'h0000, 1);
    repeat (10) step(1, 0, 0);
    add_word(16'hDCBA, 16'h0108, 1);
    repeat (10) step(1, 0, 0);

    // fill under backpressure, verify the held beat, then drain
    add_word(16'h8765, 16'h0000, 1);
    add_word(16'h3F1E, 16'h9009, 1);
    add_word(16'h5A5A, 16'h0000, 0);
    repeat (20) step(0, 0, 0);
    check_eq("full_in_ready", in_ready, 0);
    held = out_data;
    repeat (5) step(0, 0, 0);
    check_eq("held_out_data", out_data, held);
    repeat (10) step(1, 0, 0);
    add_err(16'h1234);
    repeat (10) step(1, 0, 0);

    // orphan error beat
    do_reset();
    step(1, 0, 1);
    repeat (3) step(1, 0, 0);
    check_eq("orphan_proto", proto_err, 1);

    // misframed in_first on beat 2, then 16 more beats
    do_reset();
    add_word(16'hC0DE, 16'h0210, 1);
    b = din_q[2]; b.f = 1'b1; din_q[2] = b;
    for (int w = 0; w < 4; w++) add_word(16'($urandom), 16'($urandom), 1);
    repeat (120) step(2, 1, 0);
    repeat (20) step(1, 0, 0);
    check_eq("frame_proto", proto_err, 1);

    // reset mid-word, then a clean word
    do_reset();
    add_word(16'h7777, 16'h0000, 1);
    repeat (2) step(1, 0, 0);
    do_reset();
    add_word(16'h4321, 16'h0000, 1);
    repeat (10) step(1, 0, 0);

    // random traffic
    for (int w = 0; w < 12; w++) add_word(16'($urandom), 16'($urandom) & 16'($urandom), 1);
    repeat (250) step(2, 1, 0);
    repeat (40) step(1, 0, 0);
    check_eq("drained_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
